// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX block family.
//   TX_DATA_WIDTH : default payload width used by the TX blocks
//   ser_state_t   : serializer FSM encoding (IDLE=0, SHIFT=1)
package uart_tx_pkg;

   localparam int TX_DATA_WIDTH = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

endpackage

// File: rtl/param_serializer.sv
// Parallel-to-serial converter driven by an external bit-advance strobe.
// A word is accepted on data_valid && ready, then one bit is consumed per
// ser_en while busy. After the last bit, ser_done pulses for one cycle and
// the line returns to IDLE_LEVEL; a new word may be accepted in that cycle.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active high
//   p_data     : parallel word to serialize
//   data_valid : p_data valid this cycle
//   ready      : block can accept a word (IDLE)
//   ser_en     : bit-advance strobe, consumed only while busy
//   s_data     : registered serial output
//   busy       : a word is in flight (SHIFT)
//   ser_done   : one-cycle pulse after the last bit is consumed
module param_serializer
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = TX_DATA_WIDTH,
   parameter bit MSB_FIRST  = 1'b0,
   parameter bit IDLE_LEVEL = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   output logic                  ready,
   input  logic                  ser_en,
   output logic                  s_data,
   output logic                  busy,
   output logic                  ser_done
);

   localparam int            CW   = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   ser_state_t            state, state_nxt;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] sreg;
   logic                  load, adv, fin;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      busy      = 1'b0;
      load      = 1'b0;
      adv       = 1'b0;
      fin       = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (data_valid) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (ser_en) begin
               if (cnt == LAST) begin
                  fin       = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // s_data always holds the current bit, so the shift register is advanced
   // one step ahead: the next bit to present is the one adjacent to the
   // current head of sreg.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         sreg     <= '0;
         s_data   <= IDLE_LEVEL;
         ser_done <= 1'b0;
      end else begin
         ser_done <= fin;
         if (load) begin
            cnt    <= '0;
            sreg   <= p_data;
            s_data <= MSB_FIRST ? p_data[DATA_WIDTH-1] : p_data[0];
         end else if (adv) begin
            cnt <= cnt + CW'(1);
            if (MSB_FIRST) begin
               sreg   <= {sreg[DATA_WIDTH-2:0], 1'b0};
               s_data <= sreg[DATA_WIDTH-2];
            end else begin
               sreg   <= {1'b0, sreg[DATA_WIDTH-1:1]};
               s_data <= sreg[1];
            end
         end else if (fin) begin
            cnt    <= '0;
            s_data <= IDLE_LEVEL;
         end
      end
   end

endmodule
